// File: rtl/rv_sram_ctrl_pkg.sv
// rv_sram_ctrl_pkg: shared types and constants for the 32-bit bus to 16-bit async SRAM bridge.
//   sram_state_e : controller FSM states
//   SRAM_DW      : SRAM data width
//   half_sel()   : picks the low or high 16-bit half of a 32-bit word
package rv_sram_ctrl_pkg;

   localparam int unsigned SRAM_DW = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      RESP
   } sram_state_e;

   function automatic logic [SRAM_DW-1:0] half_sel(logic [31:0] word, logic hi);
      return hi ? word[31:16] : word[15:0];
   endfunction

endpackage

// File: rtl/rv_sram_ctrl_if.sv
// rv_sram_ctrl_if: SoC-side req/gnt/rvalid data bus.
//   req, we, addr, wdata, be : request from the bus master
//   gnt, rvalid, rdata       : grant, completion pulse and read data from the slave
interface rv_sram_ctrl_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/rv_sram_ctrl.sv
// rv_sram_ctrl: bridges the 32-bit req/gnt/rvalid bus to a 16-bit asynchronous SRAM.
// Each word is accessed as two half-word phases (low half first), each phase being
// SETUP (1 cycle), PULSE (WAIT_CYCLES cycles, OE_N or WE_N low), HOLD (1 cycle).
// Write halves with no byte enables are skipped; a write with be = 0 completes at once.
// Ports:
//   clk_i, arstn_i     : clock, synchronous active-low reset
//   bus                : slave side of rv_sram_ctrl_if (req/we/addr/wdata/be, gnt/rvalid/rdata)
//   sram_data_i        : SRAM_DQ input
//   sram_addr_o        : half-word address {addr[SRAM_AW:2], half}
//   sram_data_o        : SRAM_DQ drive value
//   sram_*_n_o         : active-low SRAM strobes, all registered
module rv_sram_ctrl
   import rv_sram_ctrl_pkg::*;
#(
   parameter int unsigned SRAM_AW     = 20,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   rv_sram_ctrl_if.slave      bus,
   input  logic [SRAM_DW-1:0] sram_data_i,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [SRAM_DW-1:0] sram_data_o,
   output logic               sram_ce_n_o,
   output logic               sram_oe_n_o,
   output logic               sram_we_n_o,
   output logic               sram_ub_n_o,
   output logic               sram_lb_n_o
);

   localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

   sram_state_e        state_q, state_d;
   logic               half_q, half_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [SRAM_AW-2:0] waddr_q, waddr_d;
   logic               we_q, we_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        rdata_q, rdata_d;

   logic [SRAM_AW-1:0] saddr_q, saddr_d;
   logic [SRAM_DW-1:0] sdata_q, sdata_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic               ub_n_q, ub_n_d;
   logic               lb_n_q, lb_n_d;

   logic               active;
   logic [1:0]         lane;

   // Address bits outside [SRAM_AW:2] are intentionally ignored.
   logic unused_addr;
   assign unused_addr = ^{bus.addr[31:SRAM_AW+1], bus.addr[1:0]};

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               waddr_d = bus.addr[SRAM_AW:2];
               we_d    = bus.we;
               wdata_d = bus.wdata;
               be_d    = bus.be;
               half_d  = 1'b0;
               if (bus.we && (bus.be == 4'b0000)) begin
                  state_d = RESP;
               end else begin
                  state_d = SETUP;
                  // Skip straight to the high half when no low byte is enabled.
                  half_d  = bus.we && (bus.be[1:0] == 2'b00);
               end
            end
         end
         SETUP: begin
            state_d = PULSE;
            cnt_d   = '0;
         end
         PULSE: begin
            if (cnt_q == CntLast) begin
               state_d = HOLD;
               if (!we_q) begin
                  if (half_q) begin
                     rdata_d[31:16] = sram_data_i;
                  end else begin
                     rdata_d[15:0] = sram_data_i;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!half_q && (!we_q || (be_q[3:2] != 2'b00))) begin
               state_d = SETUP;
               half_d  = 1'b1;
            end else begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pin values are derived from the next state and registered, so the pins
   // line up with state_q and never glitch.
   always_comb begin
      active  = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
      lane    = half_d ? be_d[3:2] : be_d[1:0];
      ce_n_d  = !active;
      oe_n_d  = !((state_d == PULSE) && !we_d);
      we_n_d  = !((state_d == PULSE) && we_d);
      lb_n_d  = 1'b1;
      ub_n_d  = 1'b1;
      saddr_d = saddr_q;
      sdata_d = sdata_q;
      if (active) begin
         lb_n_d  = we_d ? !lane[0] : 1'b0;
         ub_n_d  = we_d ? !lane[1] : 1'b0;
         saddr_d = {waddr_d, half_d};
         if (we_d) begin
            sdata_d = half_sel(wdata_d, half_d);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         half_q  <= 1'b0;
         cnt_q   <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         saddr_q <= '0;
         sdata_q <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         saddr_q <= saddr_d;
         sdata_q <= sdata_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
      end
   end

   assign bus.gnt     = (state_q == IDLE);
   assign bus.rvalid  = (state_q == RESP);
   assign bus.rdata   = rdata_q;
   assign sram_addr_o = saddr_q;
   assign sram_data_o = sdata_q;
   assign sram_ce_n_o = ce_n_q;
   assign sram_oe_n_o = oe_n_q;
   assign sram_we_n_o = we_n_q;
   assign sram_ub_n_o = ub_n_q;
   assign sram_lb_n_o = lb_n_q;

endmodule

// File: tb/tb_rv_sram_ctrl.sv
// tb_rv_sram_ctrl: two controllers (WAIT_CYCLES = 1 and 3), each attached to a behavioural
// async SRAM that flags strobe overlap and address/data changes while WE_N is low.
module tb_rv_sram_ctrl;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        cur;
   logic        req_s   [2];
   logic        we_s    [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wdata_s [2];
   logic [3:0]  be_s    [2];

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] gmem [2][128];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned W = (g == 0) ? 1 : 3;

      rv_sram_ctrl_if bus ();
      logic [15:0] sd_i, sd_o;
      logic [19:0] sa;
      logic        ce_n, oe_n, we_n, ub_n, lb_n;

      assign bus.req   = req_s[g];
      assign bus.we    = we_s[g];
      assign bus.addr  = addr_s[g];
      assign bus.wdata = wdata_s[g];
      assign bus.be    = be_s[g];

      rv_sram_ctrl #(
         .SRAM_AW     (20),
         .WAIT_CYCLES (W)
      ) u_dut (
         .clk_i       (clk),
         .arstn_i     (rst_n),
         .bus         (bus),
         .sram_data_i (sd_i),
         .sram_addr_o (sa),
         .sram_data_o (sd_o),
         .sram_ce_n_o (ce_n),
         .sram_oe_n_o (oe_n),
         .sram_we_n_o (we_n),
         .sram_ub_n_o (ub_n),
         .sram_lb_n_o (lb_n)
      );

      // Async SRAM model; memory index folds the top address bit onto the low region.
      logic [15:0] mem [128];
      int          viol = 0, we_falls = 0, oe_falls = 0, ce_cycles = 0;
      int          oe_run = 0, last_oe_run = 0;
      logic [19:0] we_a = '0, prev_we_a = '0, oe_a = '0, prev_oe_a = '0;
      logic [15:0] we_dat = '0;
      logic        we_ub = 1'b1, we_lb = 1'b1, we_n_p = 1'b1, oe_n_p = 1'b1;

      assign sd_i = (!oe_n && !ce_n) ? mem[{sa[19], sa[5:0]}] : 16'hA5A5;

      always @(negedge clk) begin
         if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
         end else if (we_n && !we_n_p) begin
            mem[{we_a[19], we_a[5:0]}] <= {we_ub ? mem[{we_a[19], we_a[5:0]}][15:8] : we_dat[15:8],
                                           we_lb ? mem[{we_a[19], we_a[5:0]}][7:0]  : we_dat[7:0]};
         end
         if (!oe_n && !we_n) viol <= viol + 1;
         if ((!oe_n || !we_n) && ce_n) viol <= viol + 1;
         if (!ce_n) ce_cycles <= ce_cycles + 1;
         if (!we_n) begin
            if (we_n_p) begin
               prev_we_a <= we_a;
               we_a      <= sa;
               we_dat    <= sd_o;
               we_ub     <= ub_n;
               we_lb     <= lb_n;
               we_falls  <= we_falls + 1;
            end else if (sa !== we_a || sd_o !== we_dat || ub_n !== we_ub || lb_n !== we_lb) begin
               viol <= viol + 1;
            end
         end
         if (!oe_n) begin
            if (oe_n_p) begin
               prev_oe_a <= oe_a;
               oe_a      <= sa;
               oe_falls  <= oe_falls + 1;
               oe_run    <= 1;
            end else begin
               oe_run <= oe_run + 1;
            end
         end else if (!oe_n_p) begin
            last_oe_run <= oe_run;
         end
         we_n_p <= we_n;
         oe_n_p <= oe_n;
      end
   end

   logic        gnt_m, rvalid_m;
   logic [31:0] rdata_m;
   logic [19:0] saddr_m, we_a_m, prev_we_a_m, oe_a_m, prev_oe_a_m;
   logic [15:0] sdata_m;
   logic [4:0]  strobes_m;
   logic [1:0]  we_ublb_m;
   int          viol_m, we_falls_m, oe_falls_m, ce_cycles_m, oe_run_m;

   assign gnt_m       = cur ? g_inst[1].bus.gnt : g_inst[0].bus.gnt;
   assign rvalid_m    = cur ? g_inst[1].bus.rvalid : g_inst[0].bus.rvalid;
   assign rdata_m     = cur ? g_inst[1].bus.rdata : g_inst[0].bus.rdata;
   assign saddr_m     = cur ? g_inst[1].sa : g_inst[0].sa;
   assign sdata_m     = cur ? g_inst[1].sd_o : g_inst[0].sd_o;
   assign strobes_m   = cur ? {g_inst[1].ce_n, g_inst[1].oe_n, g_inst[1].we_n, g_inst[1].ub_n,
                               g_inst[1].lb_n}
                            : {g_inst[0].ce_n, g_inst[0].oe_n, g_inst[0].we_n, g_inst[0].ub_n,
                               g_inst[0].lb_n};
   assign we_a_m      = cur ? g_inst[1].we_a : g_inst[0].we_a;
   assign prev_we_a_m = cur ? g_inst[1].prev_we_a : g_inst[0].prev_we_a;
   assign oe_a_m      = cur ? g_inst[1].oe_a : g_inst[0].oe_a;
   assign prev_oe_a_m = cur ? g_inst[1].prev_oe_a : g_inst[0].prev_oe_a;
   assign we_ublb_m   = cur ? {g_inst[1].we_ub, g_inst[1].we_lb} : {g_inst[0].we_ub, g_inst[0].we_lb};
   assign viol_m      = cur ? g_inst[1].viol : g_inst[0].viol;
   assign we_falls_m  = cur ? g_inst[1].we_falls : g_inst[0].we_falls;
   assign oe_falls_m  = cur ? g_inst[1].oe_falls : g_inst[0].oe_falls;
   assign ce_cycles_m = cur ? g_inst[1].ce_cycles : g_inst[0].ce_cycles;
   assign oe_run_m    = cur ? g_inst[1].last_oe_run : g_inst[0].last_oe_run;

   // ---------------- reference model ----------------
   function automatic logic [6:0] gidx(logic [19:0] ha);
      return {ha[19], ha[5:0]};
   endfunction

   function automatic logic [31:0] model_read(int s, logic [31:0] a);
      logic [19:0] ha;
      ha = {a[20:2], 1'b0};
      return {gmem[s][gidx(ha | 20'h1)], gmem[s][gidx(ha)]};
   endfunction

   task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
      logic [19:0] ha;
      logic [15:0] w;
      for (int h = 0; h < 2; h++) begin
         ha = {a[20:2], h[0]};
         w  = gmem[s][gidx(ha)];
         if (b[2*h])   w[7:0]  = d[16*h +: 8];
         if (b[2*h+1]) w[15:8] = d[16*h+8 +: 8];
         gmem[s][gidx(ha)] = w;
      end
   endtask

   // Cycles from accept edge to rvalid: one T-cycle phase per accessed half, plus RESP.
   function automatic int exp_lat(int s, logic w, logic [3:0] b);
      int t;
      t = ((s != 0) ? 3 : 1) + 2;
      if (!w) return 2 * t + 1;
      return (((b[1:0] != 2'b00) ? 1 : 0) + ((b[3:2] != 2'b00) ? 1 : 0)) * t + 1;
   endfunction

   function automatic int halves(logic [3:0] b);
      return ((b[1:0] != 2'b00) ? 1 : 0) + ((b[3:2] != 2'b00) ? 1 : 0);
   endfunction

   task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output int lat);
      int guard;
      cur = (s != 0);
      @(negedge clk);
      req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = d; be_s[s] = b;
      #1;
      guard = 0;
      while (gnt_m !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         vectors++; miscompares++;
         $display("FAIL gnt_timeout: gnt=%b required 1", gnt_m);
      end
      @(posedge clk);
      #1 req_s[s] = 1'b0;
      @(negedge clk);
      lat = 1;
      while (rvalid_m !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = rdata_m;
      if (w) model_write(s, a, d, b);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b1; cur = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = '0; be_s[s] = '0;
         for (int i = 0; i < 128; i++) gmem[s][i] = '0;
      end
      repeat (3) @(negedge clk);
      clr = 1'b0;
      for (int s = 0; s < 2; s++) begin
         cur = (s != 0);
         #1;
         vectors++;
         if (strobes_m !== 5'b11111) begin
            miscompares++;
            $display("FAIL reset_strobes[%0d]: got %b required 11111", s, strobes_m);
         end
         vectors++;
         if ({rvalid_m, gnt_m} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_rvalid_gnt[%0d]: got %b required 01", s, {rvalid_m, gnt_m});
         end
         vectors++;
         if ({rdata_m, saddr_m, sdata_m} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_data[%0d]: rdata %h addr %h data %h required 0", s, rdata_m,
                     saddr_m, sdata_m);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_word();
      logic [31:0] rd;
      int lat, wf;
      cur = 1'b0; #1;
      wf = we_falls_m;
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
      vectors++;
      if (lat !== exp_lat(0, 1'b1, 4'hF)) begin
         miscompares++;
         $display("FAIL full_write_lat: got %0d required %0d", lat, exp_lat(0, 1'b1, 4'hF));
      end
      vectors++;
      if ({we_falls_m - wf, 12'h0, prev_we_a_m, we_a_m} !== {32'd2, 12'h0, 20'h8, 20'h9}) begin
         miscompares++;
         $display("FAIL full_write_pulses: pulses %0d addrs %h,%h required 2 at 8,9",
                  we_falls_m - wf, prev_we_a_m, we_a_m);
      end
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
      vectors++;
      if (rd !== model_read(0, 32'h10)) begin
         miscompares++;
         $display("FAIL full_read_data: got %h required %h", rd, model_read(0, 32'h10));
      end
      vectors++;
      if (lat !== exp_lat(0, 1'b0, 4'h0)) begin
         miscompares++;
         $display("FAIL full_read_lat: got %0d required %0d", lat, exp_lat(0, 1'b0, 4'h0));
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd;
      logic [3:0]  b;
      logic [31:0] d;
      int lat, wf;
      for (int k = 0; k < 2; k++) begin
         b = (k == 0) ? 4'h2 : 4'h4;
         d = (k == 0) ? 32'h11223344 : 32'h00550000;
         cur = 1'b0; #1;
         wf = we_falls_m;
         xfer(0, 1'b1, 32'h10, d, b, rd, lat);
         vectors++;
         if (lat !== exp_lat(0, 1'b1, b) || (we_falls_m - wf) !== 1) begin
            miscompares++;
            $display("FAIL be_write[%h]: lat %0d pulses %0d required %0d,1", b, lat,
                     we_falls_m - wf, exp_lat(0, 1'b1, b));
         end
         vectors++;
         if ({we_a_m, we_ublb_m} !== ((k == 0) ? {20'h8, ~b[1], ~b[0]} : {20'h9, ~b[3], ~b[2]}))
         begin
            miscompares++;
            $display("FAIL be_lanes[%h]: addr %h ub/lb %b", b, we_a_m, we_ublb_m);
         end
         xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
         vectors++;
         if (rd !== model_read(0, 32'h10)) begin
            miscompares++;
            $display("FAIL be_readback[%h]: got %h required %h", b, rd, model_read(0, 32'h10));
         end
      end
   endtask

   task automatic test_no_enable();
      logic [31:0] rd;
      int lat, cc;
      cur = 1'b0; #1;
      cc = ce_cycles_m;
      xfer(0, 1'b1, 32'h14, 32'h12345678, 4'h0, rd, lat);
      vectors++;
      if (lat !== 1 || (ce_cycles_m - cc) !== 0) begin
         miscompares++;
         $display("FAIL be0_write: lat %0d ce_cycles %0d required 1,0", lat, ce_cycles_m - cc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int lat, n, busy_gnt;
      xfer(0, 1'b1, 32'h20, 32'hA1B2C3D4, 4'hF, rd, lat);
      xfer(0, 1'b1, 32'h24, 32'h0BADF00D, 4'hF, rd, lat);
      cur = 1'b0;
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h20;
      n = 0;
      #1;
      while (gnt_m !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 addr_s[0] = 32'h24;
      for (int r = 0; r < 2; r++) begin
         busy_gnt = 0;
         @(negedge clk);
         n = 1;
         while (rvalid_m !== 1'b1 && n < 40) begin
            if (gnt_m) busy_gnt++;
            @(negedge clk);
            n++;
         end
         vectors++;
         if (n !== exp_lat(0, 1'b0, 4'h0) || busy_gnt !== 0 || gnt_m !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_lat[%0d]: lat %0d busy_gnt %0d gnt %b required %0d,0,0", r, n,
                     busy_gnt, gnt_m, exp_lat(0, 1'b0, 4'h0));
         end
         vectors++;
         if (rdata_m !== model_read(0, (r == 0) ? 32'h20 : 32'h24)) begin
            miscompares++;
            $display("FAIL b2b_data[%0d]: got %h required %h", r, rdata_m,
                     model_read(0, (r == 0) ? 32'h20 : 32'h24));
         end
         if (r == 0) begin
            @(negedge clk);
            vectors++;
            if ({gnt_m, rvalid_m} !== 2'b10) begin
               miscompares++;
               $display("FAIL b2b_regrant: gnt/rvalid %b required 10", {gnt_m, rvalid_m});
            end
            @(posedge clk);
            #1 req_s[0] = 1'b0;
         end
      end
   endtask

   task automatic test_reset_pulse();
      logic [31:0] rd;
      logic [31:0] d;
      int lat, n;
      d = $urandom;
      cur = 1'b0;
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = d; be_s[0] = 4'hF;
      @(posedge clk);
      #1 req_s[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (strobes_m[2] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if ({strobes_m[4], strobes_m[2], rvalid_m, gnt_m} !== 4'b1101) begin
         miscompares++;
         $display("FAIL reset_in_pulse: ce/we/rvalid/gnt %b required 1101",
                  {strobes_m[4], strobes_m[2], rvalid_m, gnt_m});
      end
      @(negedge clk);
      rst_n = 1'b1;
      // The low-half write pulse had already started, so the SRAM keeps that half.
      model_write(0, 32'h40, d, 4'h3);
      xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
      vectors++;
      if (rd !== model_read(0, 32'h40) || lat !== exp_lat(0, 1'b0, 4'h0)) begin
         miscompares++;
         $display("FAIL post_reset_read: got %h lat %0d required %h lat %0d", rd, lat,
                  model_read(0, 32'h40), exp_lat(0, 1'b0, 4'h0));
      end
   endtask

   task automatic test_wait3();
      logic [31:0] rd;
      int lat, of;
      xfer(1, 1'b1, 32'h1FFFFC, 32'hCAFEF00D, 4'hF, rd, lat);
      vectors++;
      if (lat !== exp_lat(1, 1'b1, 4'hF)) begin
         miscompares++;
         $display("FAIL w3_write_lat: got %0d required %0d", lat, exp_lat(1, 1'b1, 4'hF));
      end
      of = oe_falls_m;
      xfer(1, 1'b0, 32'h1FFFFC, 32'h0, 4'h0, rd, lat);
      vectors++;
      if (rd !== model_read(1, 32'h1FFFFC) || lat !== exp_lat(1, 1'b0, 4'h0)) begin
         miscompares++;
         $display("FAIL w3_read: got %h lat %0d required %h lat %0d", rd, lat,
                  model_read(1, 32'h1FFFFC), exp_lat(1, 1'b0, 4'h0));
      end
      vectors++;
      if ({prev_oe_a_m, oe_a_m} !== {20'hFFFFE, 20'hFFFFF} || oe_run_m !== 3 ||
          (oe_falls_m - of) !== 2) begin
         miscompares++;
         $display("FAIL w3_oe: addrs %h,%h run %0d pulses %0d required FFFFE,FFFFF 3 2",
                  prev_oe_a_m, oe_a_m, oe_run_m, oe_falls_m - of);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, d;
      logic [3:0]  b;
      logic        w;
      int          s, lat, wf, of;
      for (int i = 0; i < 24; i++) begin
         s = $urandom_range(1, 0);
         w = $urandom_range(1, 0) != 0;
         a = 32'($urandom_range(31, 0)) << 2;
         d = $urandom;
         b = 4'($urandom_range(15, 0));
         cur = (s != 0); #1;
         wf = we_falls_m; of = oe_falls_m;
         xfer(s, w, a, d, b, rd, lat);
         vectors++;
         if (lat !== exp_lat(s, w, b)) begin
            miscompares++;
            $display("FAIL rand_lat[%0d]: got %0d required %0d", i, lat, exp_lat(s, w, b));
         end
         vectors++;
         if (w && (we_falls_m - wf) !== halves(b)) begin
            miscompares++;
            $display("FAIL rand_we_pulses[%0d]: got %0d required %0d", i, we_falls_m - wf,
                     halves(b));
         end else if (!w && (rd !== model_read(s, a) || (oe_falls_m - of) !== 2)) begin
            miscompares++;
            $display("FAIL rand_read[%0d]: got %h pulses %0d required %h 2", i, rd,
                     oe_falls_m - of, model_read(s, a));
         end
      end
   endtask

   task automatic test_protocol();
      for (int s = 0; s < 2; s++) begin
         cur = (s != 0); #1;
         vectors++;
         if (viol_m !== 0) begin
            miscompares++;
            $display("FAIL sram_protocol[%0d]: violations %0d required 0", s, viol_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_byte_enable();
      test_no_enable();
      test_back_to_back();
      test_reset_pulse();
      test_wait3();
      test_random();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
